i2c_target_regs: RTL and testbench
==================================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, meaning the 7-bit I2C address this target answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on scl and sda, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 SHALL have port scl, input, 1 bit: I2C clock from the bus master; the block never drives or stretches it.
REQ-006 SHALL have port sda, inout, 1 bit: open-drain data line, driven 1'b0 when sda_oe=1, otherwise high-impedance.
REQ-007 SHALL have port address, input, 2 bits: host register select.
REQ-008 SHALL have ports chipselect and write_n, input, 1 bit each: host write strobe when chipselect=1 and write_n=0.
REQ-009 SHALL have port writedata, input, 8 bits: host write data.
REQ-010 SHALL have port readdata, output, 8 bits: registered host read data.
REQ-011 SHALL have port wr_irq, output, 1 bit: one-cycle pulse when an I2C write commits to a register.

Function
REQ-012 SHALL pass scl and sda through SYNC_STAGES flops and detect edges on the synchronized copies only.
REQ-013 SHALL detect START as a synchronized sda fall while scl=1, and STOP as a synchronized sda rise while scl=1.
REQ-014 SHALL give START and STOP precedence over bit processing in the same cycle.
REQ-015 SHALL enter ADDR on any START, including a repeated START from any state, and SHALL release sda.
REQ-016 SHALL enter IDLE on STOP from any state, and SHALL release sda.
REQ-017 SHALL sample sda MSB-first on each scl rise in ADDR, PTR and WDATA, using a 3-bit bit counter.
REQ-018 After 8 bits in ADDR, SHALL go to ADDR_ACK on match with DEV_ADDR, otherwise to IGNORE (sda released until START or STOP).
REQ-019 SHALL drive ACK by asserting sda_oe at the scl fall after the 8th rise and releasing it at the scl fall after the 9th rise.
REQ-020 After ADDR_ACK: R/W=0 SHALL go to PTR; R/W=1 SHALL load regs[ptr] into the shift register and go to RDATA.
REQ-021 In PTR, SHALL take the received byte's bits [1:0] as ptr, ACK it, then go to WDATA.
REQ-022 In WDATA, SHALL write each received byte to regs[ptr], pulse wr_irq for one clk, ACK, and increment ptr modulo 4 (3 wraps to 0).
REQ-023 In RDATA, SHALL drive each bit at the scl fall (sda_oe = ~bit), with the first bit at the scl fall ending the ACK slot; after 8 bits SHALL release sda and go to RDATA_ACK.
REQ-024 In RDATA_ACK, on the 9th scl rise: sampled 0 (ACK) SHALL increment ptr modulo 4, reload, and return to RDATA; sampled 1 (NACK) SHALL go to IGNORE.
REQ-025 The host write regs[address] <= writedata SHALL take one cycle.
REQ-026 SHALL register host reads: readdata = regs[address] one clk after the address is applied, independent of chipselect.
REQ-027 On a simultaneous host write and I2C commit to the same register, the I2C write SHALL win; writes to different registers SHALL both complete.
REQ-028 ptr SHALL persist across transactions, so a read without a preceding pointer write continues from the last ptr.

Reset
REQ-029 While reset=1 at a clk edge: state=IDLE, sda_oe=0, ptr=0, bit counter=0, regs all 8'h00, readdata=8'h00, wr_irq=0, synchronizer flops=1.
REQ-030 Reset asserted mid-transaction SHALL abort it and release sda by the next clk edge; the block SHALL resume only on a new START.

Structure
REQ-031 State encoding (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE) and the register-count constant (4) SHALL live in shared package i2c_pkg.
REQ-032 The synchronizer and edge/START/STOP detector SHALL be one sub-module, i2c_bus_sync, with outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

Verification
REQ-033 Write test: START, 0xA0, ptr 0x01, data 0x5A, 0xC3, STOP -> ACK on all 4 bytes; regs[1]=0x5A, regs[2]=0xC3; two wr_irq pulses.
REQ-034 Wrap/read test: host writes regs[3]=0x11 and regs[0]=0x22; I2C write ptr 0x03, repeated START, 0xA1, read 2 bytes with ACK then NACK -> 0x11, then 0x22.
REQ-035 Address mismatch: START, 0xA2 (addr 0x51), data -> sda never driven; regs unchanged; state IGNORE until STOP.
REQ-036 Collision: host write regs[2]=0xFF in the same clk as the I2C commit of 0x33 to regs[2] -> regs[2]=0x33.
REQ-037 Reset mid-read: assert reset while driving a 0 data bit -> sda_oe=0 after the next edge; a subsequent 0xA1 read returns 0x00 from ptr 0.
REQ-038 Host readback: address=2 -> readdata equals regs[2] one clk later; after reset readdata=0x00.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target.
package i2c_pkg;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned PTR_W    = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Synchronized bus events produced by i2c_bus_sync and consumed by the target FSM.
interface i2c_target_regs_if;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  modport master (output scl_rise, scl_fall, start_det, stop_det, sda_s);
  modport slave  (input  scl_rise, scl_fall, start_det, stop_det, sda_s);
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda and derives edge, START and STOP events.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scl,
  input  logic                sda,
  i2c_target_regs_if.master   bus
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl_s;
  logic                   w_sda_s;

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

  // Synchronizer chains plus one delayed copy for edge detection; idle bus level is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  assign bus.sda_s     = w_sda_s;
  assign bus.scl_rise  =  w_scl_s & ~r_scl_d;
  assign bus.scl_fall  = ~w_scl_s &  r_scl_d;
  assign bus.start_det =  w_scl_s & r_sda_d & ~w_sda_s;
  assign bus.stop_det  =  w_scl_s & ~r_sda_d & w_sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing four 8-bit registers, also accessible from a host port.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       wr_irq
);

  i2c_target_regs_if u_bus ();

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .scl   (scl),
    .sda   (sda),
    .bus   (u_bus)
  );

  i2c_state_e       r_state, w_state_nxt;
  logic [2:0]       r_bitcnt, w_bitcnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
  logic             r_sda_oe, w_oe_nxt;
  logic             r_phase, w_phase_nxt;  // ACK slot: 9th rise seen; RDATA: 8th rise seen
  logic             r_wr_irq;
  logic [7:0]       r_regs [NUM_REGS];
  logic [7:0]       r_readdata;
  logic [7:0]       w_byte;
  logic             w_byte_done;
  logic             w_commit;

  assign w_byte      = {r_shift[6:0], u_bus.sda_s};
  assign w_byte_done = u_bus.scl_rise && (r_bitcnt == 3'd7);
  assign w_ptr_inc   = r_ptr + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; START/STOP override any bit activity.
  always_comb begin
    w_state_nxt = r_state;
    if (u_bus.start_det)     w_state_nxt = ADDR;
    else if (u_bus.stop_det) w_state_nxt = IDLE;
    else begin
      case (r_state)
        ADDR:      if (w_byte_done) w_state_nxt = (w_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
        ADDR_ACK:  if (u_bus.scl_fall && r_phase) w_state_nxt = r_shift[0] ? RDATA : PTR;
        PTR:       if (w_byte_done) w_state_nxt = PTR_ACK;
        PTR_ACK:   if (u_bus.scl_fall && r_phase) w_state_nxt = WDATA;
        WDATA:     if (w_byte_done) w_state_nxt = WDATA_ACK;
        WDATA_ACK: if (u_bus.scl_fall && r_phase) w_state_nxt = WDATA;
        RDATA:     if (u_bus.scl_fall && r_phase) w_state_nxt = RDATA_ACK;
        RDATA_ACK: if (u_bus.scl_rise) w_state_nxt = u_bus.sda_s ? IGNORE : RDATA;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // Datapath/output next values. Read bits leave from r_shift[7] with a shift per fall;
  // entry from ADDR_ACK drives bit 7 immediately and preloads the shifted byte.
  always_comb begin
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_ptr_nxt    = r_ptr;
    w_oe_nxt     = r_sda_oe;
    w_phase_nxt  = r_phase;
    w_commit     = 1'b0;
    if (u_bus.start_det || u_bus.stop_det) begin
      w_bitcnt_nxt = '0;
      w_oe_nxt     = 1'b0;
      w_phase_nxt  = 1'b0;
    end else begin
      case (r_state)
        ADDR, PTR, WDATA: begin
          if (u_bus.scl_rise) begin
            w_shift_nxt  = w_byte;
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            w_phase_nxt  = 1'b0;
            if (w_byte_done && r_state == PTR) w_ptr_nxt = w_byte[PTR_W-1:0];
            if (w_byte_done && r_state == WDATA) begin
              w_commit  = 1'b1;
              w_ptr_nxt = w_ptr_inc;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (u_bus.scl_rise) w_phase_nxt = 1'b1;
          if (u_bus.scl_fall) begin
            if (!r_phase) begin
              w_oe_nxt = 1'b1;
            end else begin
              w_oe_nxt     = 1'b0;
              w_phase_nxt  = 1'b0;
              w_bitcnt_nxt = '0;
              if (r_state == ADDR_ACK && r_shift[0]) begin
                w_oe_nxt    = ~r_regs[r_ptr][7];
                w_shift_nxt = {r_regs[r_ptr][6:0], 1'b0};
              end
            end
          end
        end
        RDATA: begin
          if (u_bus.scl_rise) begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) w_phase_nxt = 1'b1;
          end
          if (u_bus.scl_fall) begin
            if (r_phase) begin
              w_oe_nxt    = 1'b0;
              w_phase_nxt = 1'b0;
            end else begin
              w_oe_nxt    = ~r_shift[7];
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          if (u_bus.scl_rise && !u_bus.sda_s) begin
            w_ptr_nxt    = w_ptr_inc;
            w_shift_nxt  = r_regs[w_ptr_inc];
            w_bitcnt_nxt = '0;
            w_phase_nxt  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_sda_oe <= 1'b0;
      r_phase  <= 1'b0;
      r_wr_irq <= 1'b0;
    end else begin
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_ptr    <= w_ptr_nxt;
      r_sda_oe <= w_oe_nxt;
      r_phase  <= w_phase_nxt;
      r_wr_irq <= w_commit;
    end
  end

  // Register file: I2C commit is assigned last so it wins a same-register collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_readdata <= '0;
    end else begin
      if (chipselect && !write_n) r_regs[address] <= writedata;
      if (w_commit)               r_regs[r_ptr]   <= w_byte;
      r_readdata <= r_regs[address];
    end
  end

  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign readdata = r_readdata;
  assign wr_irq   = r_wr_irq;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed plus randomized bench for i2c_target_regs with a transaction-level register model.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int Q = 6;  // clk cycles per quarter scl period

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_low;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       wr_irq;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_target_regs #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda        (sda),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .wr_irq     (wr_irq)
  );

  // Independent bus monitor used to count STOP conditions seen on the wire.
  i2c_target_regs_if u_mon ();
  i2c_bus_sync #(.SYNC_STAGES(2)) u_mon_sync (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .bus(u_mon)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0, n_fail = 0;
  int irq_cnt = 0, stop_cnt = 0, drove_cnt = 0, n_stops = 0;

  always @(negedge clk) begin
    if (wr_irq === 1'b1) irq_cnt <= irq_cnt + 1;
    if (u_mon.stop_det === 1'b1) stop_cnt <= stop_cnt + 1;
    if (!m_low && sda === 1'b0) drove_cnt <= drove_cnt + 1;
  end

  logic [7:0]  m_regs [NUM_REGS];
  int unsigned m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_low = 1'b0; wclk(Q); scl = 1'b1; wclk(Q); m_low = 1'b1; wclk(Q); scl = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop;
    m_low = 1'b1; wclk(Q); scl = 1'b1; wclk(Q); m_low = 1'b0; wclk(Q);
    n_stops++;
  endtask

  task automatic bit_out(input logic b);
    m_low = ~b; wclk(Q); scl = 1'b1; wclk(2 * Q); scl = 1'b0; wclk(Q);
  endtask

  task automatic bit_in(output logic b);
    m_low = 1'b0; wclk(Q); scl = 1'b1; wclk(Q); b = sda; wclk(Q); scl = 1'b0; wclk(Q);
  endtask

  // With collide=1 the host writes regs[2]=FF in the cycle the target commits the byte.
  task automatic write_byte(input logic [7:0] d, output logic ack, input logic collide);
    for (int i = 7; i >= 1; i--) bit_out(d[i]);
    if (!collide) begin
      bit_out(d[0]);
    end else begin
      m_low = ~d[0]; wclk(Q); scl = 1'b1;
      wclk(2);
      chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 8'hFF;
      wclk(1);
      chk("collide_align_irq", wr_irq, 1'b1);
      chipselect = 1'b0; write_n = 1'b1;
      wclk(2 * Q - 3); scl = 1'b0; wclk(Q);
    end
    bit_in(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) bit_in(d[i]);
    bit_out(nack);
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    wclk(1);
    chipselect = 1'b0; write_n = 1'b1;
    m_regs[a] = d;
  endtask

  task automatic host_check(input logic [1:0] a, input string tag);
    address = a;
    wclk(1);
    chk(tag, readdata, m_regs[a]);
  endtask

  logic [7:0] d;
  logic       ack;
  int         irq0, drove0, n;
  logic [7:0] p;

  initial begin
    reset = 1'b1; scl = 1'b1; m_low = 1'b0;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    wclk(4);
    chk("rst_readdata", readdata, 8'h00);
    reset = 1'b0;
    wclk(2);
    chk("rst_sda_released", sda, 1'b1);
    chk("rst_wr_irq", wr_irq, 1'b0);
    for (int i = 0; i < NUM_REGS; i++) host_check(2'(i), "rst_regs");

    // Write transaction with pointer 1 and two data bytes.
    irq0 = irq_cnt;
    i2c_start;
    write_byte(8'hA0, ack, 1'b0); chk("wr_addr_ack", ack, 1'b0);
    write_byte(8'h01, ack, 1'b0); chk("wr_ptr_ack", ack, 1'b0);
    write_byte(8'h5A, ack, 1'b0); chk("wr_d0_ack", ack, 1'b0);
    write_byte(8'hC3, ack, 1'b0); chk("wr_d1_ack", ack, 1'b0);
    i2c_stop;
    m_regs[1] = 8'h5A; m_regs[2] = 8'hC3; m_ptr = 3;
    chk("wr_irq_pulses", irq_cnt - irq0, 2);
    host_check(2'd1, "wr_reg1");
    host_check(2'd2, "wr_reg2");

    // Pointer wrap on read: 3 then 0.
    host_write(2'd3, 8'h11);
    host_write(2'd0, 8'h22);
    i2c_start;
    write_byte(8'hA0, ack, 1'b0); chk("wrap_addr_ack", ack, 1'b0);
    write_byte(8'h03, ack, 1'b0); chk("wrap_ptr_ack", ack, 1'b0);
    m_ptr = 3;
    i2c_start;
    write_byte(8'hA1, ack, 1'b0); chk("wrap_rd_addr_ack", ack, 1'b0);
    read_byte(d, 1'b0); chk("wrap_rd0", d, m_regs[m_ptr]);
    m_ptr = (m_ptr + 1) % NUM_REGS;
    read_byte(d, 1'b1); chk("wrap_rd1", d, m_regs[m_ptr]);
    i2c_stop;

    // Address mismatch: target must stay silent and leave registers alone.
    irq0 = irq_cnt; drove0 = drove_cnt;
    i2c_start;
    write_byte(8'hA2, ack, 1'b0); chk("miss_addr_nack", ack, 1'b1);
    write_byte(8'($urandom), ack, 1'b0); chk("miss_data_nack", ack, 1'b1);
    i2c_stop;
    chk("miss_never_driven", drove_cnt - drove0, 0);
    chk("miss_no_irq", irq_cnt - irq0, 0);
    for (int i = 0; i < NUM_REGS; i++) host_check(2'(i), "miss_regs");

    // Host write and I2C commit hit regs[2] in the same clk.
    i2c_start;
    write_byte(8'hA0, ack, 1'b0);
    write_byte(8'h02, ack, 1'b0);
    write_byte(8'h33, ack, 1'b1); chk("collide_ack", ack, 1'b0);
    i2c_stop;
    m_regs[2] = 8'hFF; m_regs[2] = 8'h33; m_ptr = 3;
    host_check(2'd2, "collide_reg2");

    // Randomized write bursts followed by read-back through I2C and host port.
    for (int t = 0; t < 4; t++) begin
      host_write(2'($urandom_range(0, 3)), 8'($urandom));
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      irq0 = irq_cnt;
      i2c_start;
      write_byte(8'hA0, ack, 1'b0);
      write_byte(p, ack, 1'b0);
      m_ptr = p % NUM_REGS;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        write_byte(d, ack, 1'b0); chk("rnd_wr_ack", ack, 1'b0);
        m_regs[m_ptr] = d;
        m_ptr = (m_ptr + 1) % NUM_REGS;
      end
      i2c_stop;
      chk("rnd_irq_pulses", irq_cnt - irq0, n);
      i2c_start;
      write_byte(8'hA0, ack, 1'b0);
      write_byte(p, ack, 1'b0);
      m_ptr = p % NUM_REGS;
      i2c_start;
      write_byte(8'hA1, ack, 1'b0);
      for (int k = 0; k < n; k++) begin
        read_byte(d, (k == n - 1));
        chk("rnd_rd", d, m_regs[m_ptr]);
        if (k != n - 1) m_ptr = (m_ptr + 1) % NUM_REGS;
      end
      i2c_stop;
      for (int i = 0; i < NUM_REGS; i++) host_check(2'(i), "rnd_host_rd");
    end

    // Read with no pointer write continues from the persisted pointer.
    i2c_start;
    write_byte(8'hA1, ack, 1'b0);
    read_byte(d, 1'b1); chk("persist_ptr_rd", d, m_regs[m_ptr]);
    i2c_stop;

    // Reset while the target drives a 0 data bit.
    host_write(2'(m_ptr), 8'h3C);
    i2c_start;
    write_byte(8'hA1, ack, 1'b0); chk("rstmid_addr_ack", ack, 1'b0);
    chk("rstmid_driving0", sda, 1'b0);
    reset = 1'b1;
    wclk(1);
    chk("rstmid_released", sda, 1'b1);
    wclk(2);
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    wclk(Q);
    i2c_start;
    write_byte(8'hA1, ack, 1'b0); chk("rstmid_rd_ack", ack, 1'b0);
    read_byte(d, 1'b1); chk("rstmid_rd_ptr0", d, m_regs[0]);
    i2c_stop;
    host_check(2'd2, "rstmid_reg2");

    wclk(4);
    chk("stop_count", stop_cnt, n_stops);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
